// File: rtl/n1_program_loader.sv
// rtl/n1_program_loader.sv - byte-stream program loader for the n1 instruction RAM
module n1_program_loader #(
  parameter int RAM_SIZE  = 128,
  parameter int ADDR_BITS = $clog2(RAM_SIZE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_start,
  input  logic                 i_abort,
  input  logic [7:0]           i_byte_in,
  input  logic                 i_byte_valid,
  output logic                 o_byte_ready,
  output logic                 o_mem_we,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [15:0]          o_mem_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_cpu_run,
  output logic [ADDR_BITS:0]   o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t               r_state;
  logic [7:0]           r_count_n;
  logic [7:0]           r_hi;
  logic [7:0]           r_csum;
  logic [ADDR_BITS-1:0] r_addr;
  logic [15:0]          r_wdata;
  logic [ADDR_BITS:0]   r_words;

  logic w_accept;
  logic w_last_word;
  logic w_count_bad;

  assign w_accept    = i_byte_valid & o_byte_ready;
  assign w_last_word = (32'(r_words) + 32'd1) == 32'(r_count_n);
  assign w_count_bad = (i_byte_in == 8'd0) || (32'(i_byte_in) > RAM_SIZE);

  // Status and handshake decode straight from the state register; the write
  // strobe is gated by abort so an aborted WRITE cycle never reaches the RAM.
  always_comb begin
    o_byte_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_mem_we     = 1'b0;
    case (r_state)
      S_COUNT, S_HI, S_LO, S_CHECK: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      S_WRITE: begin
        o_busy   = 1'b1;
        o_mem_we = ~i_abort;
      end
      S_DONE:  o_done  = 1'b1;
      S_ERR:   o_error = 1'b1;
      default: ;
    endcase
  end

  assign o_cpu_run      = o_done;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_wdata;
  assign o_words_loaded = r_words;

  // Load sequencer: count byte, N high/low word pairs, then the checksum byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_count_n <= '0;
      r_hi      <= '0;
      r_csum    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_words   <= '0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_load_start) begin
            r_state <= S_COUNT;
            r_words <= '0;
            r_addr  <= '0;
            r_csum  <= '0;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            r_count_n <= i_byte_in;
            r_state   <= w_count_bad ? S_ERR : S_HI;
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_hi    <= i_byte_in;
            r_csum  <= r_csum ^ i_byte_in;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_wdata <= {r_hi, i_byte_in};
            r_csum  <= r_csum ^ i_byte_in;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_words <= r_words + 1'b1;
          if (w_last_word) begin
            // Address holds on the final word so it never wraps past RAM_SIZE-1.
            r_state <= S_CHECK;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_HI;
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_state <= (i_byte_in == r_csum) ? S_DONE : S_ERR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n1_program_loader.sv
// tb/tb_n1_program_loader.sv - randomized self-checking bench for n1_program_loader
module tb_n1_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_run;
  logic [7:0]  words_loaded;

  n1_program_loader #(.RAM_SIZE(128)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_abort(abort),
    .i_byte_in(byte_in), .i_byte_valid(byte_valid), .o_byte_ready(byte_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_busy(busy), .o_done(done), .o_error(error), .o_cpu_run(cpu_run),
    .o_words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  tx_q[$];
  logic [22:0] wr_q[$];
  logic [22:0] exp_q[$];
  int viol;
  int max_addr;
  bit exp_done;
  bit exp_err;
  int exp_words;
  int exp_accept;
  int exp_last_addr;

  // Write monitor: records every RAM write and flags byte_ready during a write.
  always @(negedge clk) begin
    #2;
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      if (byte_ready) viol++;
      if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end
  end

  // Reference: what a loader must do with the stream in tx_q.
  function automatic void build_model();
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'(tx_q[0]);
    x = 8'h00;
    if (n == 0 || n > 128) begin
      exp_err = 1; exp_done = 0; exp_words = 0; exp_accept = 1; exp_last_addr = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({7'(i), tx_q[1+2*i], tx_q[2+2*i]});
      x = x ^ tx_q[1+2*i] ^ tx_q[2+2*i];
    end
    exp_words     = n;
    exp_accept    = 2*n + 2;
    exp_done      = (tx_q[2*n+1] == x);
    exp_err       = !exp_done;
    exp_last_addr = n - 1;
  endfunction

  function automatic void make_stream(input int n, input bit bad, input bit seq);
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;
    tx_q.delete();
    tx_q.push_back(8'(n));
    if (n == 0 || n > 128) return;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      hi = seq ? 8'(i >> 8) : 8'($urandom);
      lo = seq ? 8'(i)      : 8'($urandom);
      tx_q.push_back(hi);
      tx_q.push_back(lo);
      x = x ^ hi ^ lo;
    end
    tx_q.push_back(bad ? (x ^ 8'h01) : x);
  endfunction

  function automatic void set_basic(input logic [7:0] csum);
    tx_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, csum};
  endfunction

  // Present one byte until it is accepted; mode 0 steady, 1 toggle + gap, 2 random.
  task automatic send_byte(input logic [7:0] b, input int mode, input int idx, output bit ok);
    int cyc;
    bit xfer;
    cyc = 0;
    ok  = 0;
    while (cyc < 300) begin
      byte_in = b;
      case (mode)
        0: byte_valid = 1'b1;
        1: byte_valid = (idx == 2 && cyc < 5) ? 1'b0 : (cyc % 2 == 1);
        default: begin
          byte_valid = ($urandom % 3 != 0);
          load_start = ($urandom % 4 == 0);
        end
      endcase
      #1 xfer = byte_valid && byte_ready;
      @(negedge clk);
      cyc++;
      if (xfer) begin
        ok = 1;
        break;
      end
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  task automatic run_load(input int mode, input string name);
    bit ok;
    build_model();
    wr_q.delete();
    viol = 0;
    max_addr = 0;
    start_load();
    for (int i = 0; i < exp_accept; i++) begin
      send_byte(tx_q[i], mode, i, ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL %s timeout: byte %0d never accepted", name, i);
        break;
      end
    end
    repeat (3) @(negedge clk);
    #3;
    n_tests++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d want %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_tests++;
      if (wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write%0d: got %h want %h", name, i, wr_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if ({done, error, cpu_run, busy, byte_ready} !== {exp_done, exp_err, exp_done, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s flags(done,err,run,busy,rdy): got %b want %b", name,
               {done, error, cpu_run, busy, byte_ready}, {exp_done, exp_err, exp_done, 2'b00});
    end
    n_tests++;
    if (int'(words_loaded) !== exp_words) begin
      n_fail++;
      $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, exp_words);
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL %s ready_in_write: got %0d want 0", name, viol);
    end
    if (exp_accept > 1) begin
      n_tests++;
      if (int'(mem_addr) !== exp_last_addr) begin
        n_fail++;
        $display("FAIL %s last_addr: got %0d want %0d", name, mem_addr, exp_last_addr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({byte_ready, mem_we, busy, done, error, cpu_run, words_loaded, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want all zero",
               {byte_ready, mem_we, busy, done, error, cpu_run, words_loaded, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_basic(8'h40);
    run_load(0, "basic");
    n_tests++;
    if (wr_q.size() != 2 || wr_q[0] !== 23'h001234 || wr_q[1] !== {7'd1, 16'hABCD} || cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_fixed: got n=%0d run=%b want 0x1234@0 0xABCD@1 run=1", wr_q.size(), cpu_run);
    end
  endtask

  task automatic test_bad_checksum();
    set_basic(8'h41);
    run_load(0, "bad_csum");
  endtask

  task automatic test_invalid_count();
    make_stream(0, 0, 0);
    run_load(0, "count_00");
    make_stream(129, 0, 0);
    run_load(0, "count_81");
  endtask

  task automatic test_backpressure();
    set_basic(8'h40);
    run_load(1, "backpressure");
  endtask

  task automatic test_full_ram();
    make_stream(128, 0, 1);
    run_load(0, "full_ram");
    n_tests++;
    if (max_addr !== 127) begin
      n_fail++;
      $display("FAIL full_ram_max_addr: got %0d want 127", max_addr);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      make_stream($urandom_range(1, 24), ($urandom % 4 == 0), 0);
      run_load(2, "random");
    end
    make_stream($urandom_range(129, 255), 0, 0);
    run_load(2, "random_badcount");
  endtask

  task automatic test_abort();
    bit ok;
    set_basic(8'h40);
    wr_q.delete();
    start_load();
    for (int i = 0; i < 4; i++) send_byte(tx_q[i], 0, i, ok);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_tests++;
    if ({busy, done, error} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_flags: got %b want 000", {busy, done, error});
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (wr_q.size() != 1 || wr_q[0] !== 23'h001234) begin
      n_fail++;
      $display("FAIL abort_writes: got n=%0d want 1 write of 0x1234@0", wr_q.size());
    end
    wr_q.delete();
    start_load();
    for (int i = 0; i < 3; i++) send_byte(tx_q[i], 0, i, ok);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wr_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_write: got writes=%0d busy=%b want 0 0", wr_q.size(), busy);
    end
    @(negedge clk) begin load_start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin load_start = 1'b0; abort = 1'b0; end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_vs_abort: got busy=%b want 0", busy);
    end
    set_basic(8'h40);
    run_load(0, "after_abort");
  endtask

  task automatic test_rst_done();
    set_basic(8'h40);
    run_load(0, "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({cpu_run, done, busy, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_rst: got %b want 0000", {cpu_run, done, busy, mem_we});
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_invalid_count();
    test_backpressure();
    test_full_ram();
    test_random();
    test_abort();
    test_rst_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n1_program_loader.md
Name: n1_program_loader

Overview:
- Upstream stage of the n1 CPU core. Receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into 16-bit instruction words, writes them into the CPU instruction RAM, and verifies a trailing XOR checksum.
- Releases the core (cpu_run) only after a clean load. Replaces hand-poking RAM through the reset-time write path.

Parameters:
- RAM_SIZE, 128, number of 16-bit words in instruction RAM.
- ADDR_BITS, $clog2(RAM_SIZE), width of mem_addr.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- abort  input  1  level; forces return to IDLE from any state.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts byte_in this cycle.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_addr  output  ADDR_BITS  RAM word address.
- mem_wdata  output  16  RAM write data.
- busy  output  1  high in COUNT, HI, LO, WRITE, CHECK.
- done  output  1  high in DONE.
- error  output  1  high in ERR.
- cpu_run  output  1  core enable; equals done.
- words_loaded  output  ADDR_BITS+1  number of words written in the current or last load.

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal count, address, high-byte and checksum registers cleared.
- Handshake: a byte transfers on a rising edge when byte_valid & byte_ready. byte_ready is combinational from state: 1 in COUNT, HI, LO and CHECK; 0 elsewhere.
- Stream format:
  - Byte 0: word count N.
  - Then N words, high byte first.
  - Then one checksum byte equal to the XOR of all 2N data bytes. The count byte is excluded.
- IDLE: on load_start go to COUNT. Clear words_loaded, address (0) and checksum accumulator (0).
- COUNT: on accept, latch N.
  - N==0 or N>RAM_SIZE -> ERR.
  - Otherwise -> HI.
- HI: on accept, latch high byte, XOR it into the checksum -> LO.
- LO: on accept, form {hi, byte_in} into mem_wdata, XOR byte_in into the checksum -> WRITE.
- WRITE (exactly one cycle, byte_ready=0):
  - mem_we=1, mem_addr=current address, mem_wdata held.
  - Next edge: address+1, words_loaded+1.
  - If words_loaded+1==N -> CHECK, else -> HI.
- CHECK: on accept, compare byte_in to the accumulator. Equal -> DONE, else -> ERR.
- DONE: done=1, cpu_run=1. Holds until load_start (-> COUNT, cpu_run drops the same edge) or abort/rst.
- ERR: error=1, cpu_run=0. Holds until load_start (-> COUNT) or abort/rst. Words already written stay in RAM (no rollback).
- Latency:
  - Minimum 3 cycles per word (HI, LO, WRITE).
  - The write appears 1 cycle after the LO byte is accepted.
  - A full load takes at least 1+3N+1 cycles after load_start.
- Back-pressure: byte_valid may drop at any time. The state holds, and no partial word is ever written.
- abort: has priority over load_start and the handshake. The next state is IDLE; all flags clear; mem_we is forced 0 that cycle.
- Simultaneous load_start and abort: abort wins.
- load_start while busy: ignored.
- Address never wraps: N<=RAM_SIZE is guaranteed by the COUNT check, so the maximum mem_addr is RAM_SIZE-1.
- rst mid-load: immediate return to IDLE, mem_we=0 asynchronously. The RAM contents are undefined for the interrupted word only.

Test Plan:
- Basic load: load_start; stream 02, 12,34, AB,CD, checksum 12^34^AB^CD=40 -> writes 0x1234@0 and 0xABCD@1, one mem_we each; done=1, cpu_run=1, words_loaded=2.
- Bad checksum: same stream with checksum 41 -> both words written, error=1, cpu_run=0, done=0.
- Invalid count: counts 00 and 81 (RAM_SIZE=128) -> ERR right after the count byte; no mem_we; byte_ready=0 afterwards.
- Back-pressure: basic stream with byte_valid toggled 1/0 each cycle plus a 5-cycle gap between the HI and LO bytes -> identical writes and result; byte_ready=0 during every WRITE cycle.
- Full RAM: N=0x80, words 0x0000..0x007F -> final mem_addr=127, words_loaded=128, done=1; the address never exceeds 127.
- Abort and reset: abort asserted after the 3rd data byte -> IDLE, busy=0 and no further mem_we. Then a fresh load_start with the basic stream succeeds. Separately, rst pulsed in DONE -> cpu_run=0 asynchronously.
